// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch-request unit: picks the next PC from sequential, redirect,
// trap entry or trap return, with stall and debug halt/resume.
module pc_fetch_unit #(
    parameter int unsigned               ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0]   RESET_VECTOR = '0,
    parameter logic [ADDRESS_SIZE-1:0]   TRAP_VECTOR  = ADDRESS_SIZE'(32'h0000_0100),
    parameter int unsigned               INSTR_BYTES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_target,
    input  logic                    trap_valid,
    input  logic                    mret_valid,
    input  logic                    halt_req,
    input  logic                    resume_req,
    input  logic                    fetch_ready,
    output logic                    fetch_valid,
    output logic [ADDRESS_SIZE-1:0] fetch_addr,
    output logic [ADDRESS_SIZE-1:0] epc,
    output logic                    misaligned,
    output logic                    halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ADDRESS_SIZE'(INSTR_BYTES - 1);
    localparam logic [ADDRESS_SIZE-1:0] PC_STEP    = ADDRESS_SIZE'(INSTR_BYTES);

    state_e                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] pc_q, pc_d;
    logic [ADDRESS_SIZE-1:0] epc_q, epc_d;
    logic                    misaligned_q, misaligned_d;

    logic mret_bad, redirect_bad;

    assign mret_bad     = (epc_q & ALIGN_MASK) != '0;
    assign redirect_bad = (redirect_target & ALIGN_MASK) != '0;

    // fetch_valid follows stall in the same cycle; the address itself is always a flop
    assign fetch_valid = (state_q == RUN) && !stall;
    assign fetch_addr  = pc_q;
    assign epc         = epc_q;
    assign misaligned  = misaligned_q;
    assign halted      = (state_q == HALT);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        misaligned_d = 1'b0;

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (trap_valid) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = pc_q;
                end else if (mret_valid) begin
                    if (mret_bad) begin
                        // offending target is already in epc, so it stays put
                        pc_d         = TRAP_VECTOR;
                        misaligned_d = 1'b1;
                    end else begin
                        pc_d = epc_q;
                    end
                end else if (redirect_valid) begin
                    if (redirect_bad) begin
                        pc_d         = TRAP_VECTOR;
                        epc_d        = redirect_target;
                        misaligned_d = 1'b1;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (fetch_valid && fetch_ready) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            HALT: begin
                if (trap_valid) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = pc_q;
                end else if (resume_req && !halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            misaligned_q <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scenario tests plus a randomized run against a behavioural PC model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        trap_valid = 1'b0;
    logic        mret_valid = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume_req = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic [31:0] epc;
    logic        misaligned;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_pc = '0, m_epc = '0;
    bit          m_boot = 1'b1, m_halt = 1'b0, m_mis = 1'b0;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .mret_valid(mret_valid),
        .halt_req(halt_req), .resume_req(resume_req), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .epc(epc),
        .misaligned(misaligned), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [31:0] pc_n = m_pc, epc_n = m_epc;
        bit boot_n = m_boot, halt_n = m_halt, mis_n = 1'b0;
        if (!rst_n) begin
            pc_n = 32'h0; epc_n = 32'h0; boot_n = 1'b1; halt_n = 1'b0;
        end else if (m_boot) begin
            boot_n = 1'b0;
        end else if (m_halt) begin
            if (trap_valid) begin epc_n = m_pc; pc_n = 32'h100; end
            else if (resume_req && !halt_req) halt_n = 1'b0;
        end else begin
            if (trap_valid) begin
                epc_n = m_pc; pc_n = 32'h100;
            end else if (mret_valid) begin
                if (m_epc % 4 != 0) begin pc_n = 32'h100; mis_n = 1'b1; end
                else pc_n = m_epc;
            end else if (redirect_valid) begin
                if (redirect_target % 4 != 0) begin
                    epc_n = redirect_target; pc_n = 32'h100; mis_n = 1'b1;
                end else pc_n = redirect_target;
            end else if (halt_req) begin
                halt_n = 1'b1;
            end else if (!stall && fetch_ready) begin
                pc_n = m_pc + 32'd4;
            end
        end
        m_pc = pc_n; m_epc = epc_n; m_boot = boot_n; m_halt = halt_n; m_mis = mis_n;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; redirect_valid = 0; trap_valid = 0; mret_valid = 0;
        halt_req = 0; resume_req = 0; fetch_ready = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        tick(); tick();
        checks++; if (fetch_addr !== 32'h0 || fetch_valid !== 1'b0 || epc !== 32'h0 ||
                      misaligned !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset: addr=%h valid=%b epc=%h mis=%b halted=%b",
                               fetch_addr, fetch_valid, epc, misaligned, halted);
        end
        rst_n = 1;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL boot_valid: got %b want 0", fetch_valid);
        end
        tick();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            checks++; if (fetch_addr !== 32'(4 * i) || fetch_valid !== 1'b1) begin
                errors++; $display("FAIL seq%0d: addr=%h valid=%b want addr=%h valid=1",
                                   i, fetch_addr, fetch_valid, 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_ready_hold();
        fetch_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fetch_addr !== 32'h10 || fetch_valid !== 1'b1) begin
                errors++; $display("FAIL ready_hold%0d: addr=%h valid=%b want 10/1",
                                   i, fetch_addr, fetch_valid);
            end
        end
        fetch_ready = 1;
        tick();
        checks++; if (fetch_addr !== 32'h14) begin
            errors++; $display("FAIL ready_resume: addr=%h want 14", fetch_addr);
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1; fetch_ready = 0;
        redirect_valid = 1; redirect_target = 32'h200;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin
            errors++; $display("FAIL stall_valid: got %b want 0", fetch_valid);
        end
        tick();
        checks++; if (fetch_addr !== 32'h200) begin
            errors++; $display("FAIL redirect_stall: addr=%h want 200", fetch_addr);
        end
        redirect_target = 32'h300; trap_valid = 1;
        tick();
        checks++; if (fetch_addr !== 32'h100 || epc !== 32'h200) begin
            errors++; $display("FAIL trap_over_redirect: addr=%h epc=%h want 100/200",
                               fetch_addr, epc);
        end
        idle();
    endtask

    task automatic test_misaligned();
        redirect_valid = 1; redirect_target = 32'h202;
        tick();
        redirect_valid = 0;
        checks++; if (fetch_addr !== 32'h100 || epc !== 32'h202 || misaligned !== 1'b1) begin
            errors++; $display("FAIL mis_redirect: addr=%h epc=%h mis=%b want 100/202/1",
                               fetch_addr, epc, misaligned);
        end
        tick();
        checks++; if (misaligned !== 1'b0 || fetch_addr !== 32'h104) begin
            errors++; $display("FAIL mis_pulse: mis=%b addr=%h want 0/104", misaligned, fetch_addr);
        end
        mret_valid = 1;
        tick();
        mret_valid = 0;
        checks++; if (fetch_addr !== 32'h100 || epc !== 32'h202 || misaligned !== 1'b1) begin
            errors++; $display("FAIL mis_mret: addr=%h epc=%h mis=%b want 100/202/1",
                               fetch_addr, epc, misaligned);
        end
        tick();
        trap_valid = 1; mret_valid = 1;
        tick();
        trap_valid = 0; mret_valid = 0;
        checks++; if (fetch_addr !== 32'h100 || epc !== 32'h104 || misaligned !== 1'b0) begin
            errors++; $display("FAIL trap_vs_mret: addr=%h epc=%h mis=%b want 100/104/0",
                               fetch_addr, epc, misaligned);
        end
        mret_valid = 1;
        tick();
        mret_valid = 0;
        checks++; if (fetch_addr !== 32'h104) begin
            errors++; $display("FAIL mret_ok: addr=%h want 104", fetch_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        tick();
        checks++; if (fetch_addr !== 32'h0) begin
            errors++; $display("FAIL wrap: addr=%h want 0", fetch_addr);
        end
    endtask

    task automatic test_halt();
        redirect_valid = 1; redirect_target = 32'h40;
        tick();
        redirect_valid = 0; halt_req = 1;
        tick();
        checks++; if (halted !== 1'b1 || fetch_valid !== 1'b0 || fetch_addr !== 32'h40) begin
            errors++; $display("FAIL halt_enter: halted=%b valid=%b addr=%h want 1/0/40",
                               halted, fetch_valid, fetch_addr);
        end
        resume_req = 1;
        tick();
        checks++; if (halted !== 1'b1) begin
            errors++; $display("FAIL resume_blocked: halted=%b want 1", halted);
        end
        halt_req = 0;
        tick();
        resume_req = 0;
        checks++; if (halted !== 1'b0 || fetch_valid !== 1'b1 || fetch_addr !== 32'h40) begin
            errors++; $display("FAIL resume: halted=%b valid=%b addr=%h want 0/1/40",
                               halted, fetch_valid, fetch_addr);
        end
        tick();
        halt_req = 1;
        tick();
        trap_valid = 1;
        tick();
        trap_valid = 0;
        checks++; if (halted !== 1'b1 || fetch_addr !== 32'h100 || epc !== 32'h44) begin
            errors++; $display("FAIL halt_trap: halted=%b addr=%h epc=%h want 1/100/44",
                               halted, fetch_addr, epc);
        end
        rst_n = 0; trap_valid = 1;
        tick();
        checks++; if (halted !== 1'b0 || fetch_addr !== 32'h0 || fetch_valid !== 1'b0 ||
                      epc !== 32'h0) begin
            errors++; $display("FAIL halt_reset: halted=%b addr=%h valid=%b epc=%h want 0/0/0/0",
                               halted, fetch_addr, fetch_valid, epc);
        end
        rst_n = 1; idle();
        tick();
        checks++; if (fetch_valid !== 1'b1 || fetch_addr !== 32'h0) begin
            errors++; $display("FAIL reboot: valid=%b addr=%h want 1/0", fetch_valid, fetch_addr);
        end
    endtask

    task automatic test_random();
        bit exp_valid;
        for (int i = 0; i < 600; i++) begin
            rst_n          = ($urandom_range(99) != 0);
            stall          = ($urandom_range(3) == 0);
            fetch_ready    = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(5) == 0);
            redirect_target = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(4) == 0) redirect_target[1] = 1'b1;
            trap_valid     = ($urandom_range(11) == 0);
            mret_valid     = ($urandom_range(9) == 0);
            if ($urandom_range(15) == 0) halt_req = ~halt_req;
            resume_req     = ($urandom_range(3) == 0);
            #1;
            exp_valid = !m_boot && !m_halt && !stall;
            checks++; if (fetch_valid !== exp_valid || fetch_addr !== m_pc || epc !== m_epc ||
                          misaligned !== m_mis || halted !== m_halt) begin
                errors++;
                $display("FAIL rand%0d: valid=%b addr=%h epc=%h mis=%b halted=%b want %b/%h/%h/%b/%b",
                         i, fetch_valid, fetch_addr, epc, misaligned, halted,
                         exp_valid, m_pc, m_epc, m_mis, m_halt);
            end
            tick();
        end
        idle(); rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ready_hold();
        test_redirect_stall();
        test_misaligned();
        test_wrap();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
